// File: rtl/axil_read_arbiter.sv
// Round-robin AXI-Lite read arbiter: NUM_MASTERS requesters share one downstream
// read slave, one transaction in flight, out-of-range reads answered with DECERR.
module axil_read_arbiter #(
  parameter int                    NUM_MASTERS = 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = 32'h0000_1000,
  localparam int                   IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              S_AXIL_ACLK,
  input  logic                              S_AXIL_ARESET,
  input  logic [NUM_MASTERS-1:0]            S_AXIL_ARVALID,
  output logic [NUM_MASTERS-1:0]            S_AXIL_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] S_AXIL_ARADDR,
  input  logic [NUM_MASTERS*3-1:0]          S_AXIL_ARPROT,
  output logic [NUM_MASTERS-1:0]            S_AXIL_RVALID,
  input  logic [NUM_MASTERS-1:0]            S_AXIL_RREADY,
  output logic [DATA_WIDTH-1:0]             S_AXIL_RDATA,
  output logic [1:0]                        S_AXIL_RRESP,
  output logic                              M_AXIL_ARVALID,
  input  logic                              M_AXIL_ARREADY,
  output logic [ADDR_WIDTH-1:0]             M_AXIL_ARADDR,
  output logic [2:0]                        M_AXIL_ARPROT,
  input  logic                              M_AXIL_RVALID,
  output logic                              M_AXIL_RREADY,
  input  logic [DATA_WIDTH-1:0]             M_AXIL_RDATA,
  input  logic [1:0]                        M_AXIL_RRESP,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ADDR_ACCEPT = 3'd1,
    SLV_ADDR    = 3'd2,
    SLV_DATA    = 3'd3,
    RESP        = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IDX_W-1:0]        grant_r;
  logic [IDX_W-1:0]        last_grant_r;
  logic                    m_arvalid_r;
  logic [ADDR_WIDTH-1:0]   m_araddr_r;
  logic [2:0]              m_arprot_r;
  logic [DATA_WIDTH-1:0]   s_rdata_r;
  logic [1:0]              s_rresp_r;

  logic                    req_any_s;
  logic                    pick_found_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [2:0]              sel_prot_s;
  logic                    in_range_s;
  logic                    rready_sel_s;
  logic [NUM_MASTERS-1:0]  arready_s;
  logic [NUM_MASTERS-1:0]  rvalid_s;

  assign req_any_s    = |S_AXIL_ARVALID;
  assign sel_addr_s   = S_AXIL_ARADDR[int'(grant_r)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_prot_s   = S_AXIL_ARPROT[int'(grant_r)*3 +: 3];
  assign in_range_s   = (sel_addr_s < ADDR_LIMIT);
  assign rready_sel_s = S_AXIL_RREADY[grant_r];

  // Round-robin pick: first requester searching upward from last_grant+1, wrapping
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = last_grant_r;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!pick_found_s && S_AXIL_ARVALID[(int'(last_grant_r) + i) % NUM_MASTERS]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'((int'(last_grant_r) + i) % NUM_MASTERS);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // State register
  always_ff @(posedge S_AXIL_ACLK) begin
    if (S_AXIL_ARESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) state_nxt_s = ADDR_ACCEPT;
        else           state_nxt_s = IDLE;
      end
      ADDR_ACCEPT: begin
        if (in_range_s) state_nxt_s = SLV_ADDR;
        else            state_nxt_s = RESP;
      end
      SLV_ADDR: begin
        if (M_AXIL_ARREADY) state_nxt_s = SLV_DATA;
        else                state_nxt_s = SLV_ADDR;
      end
      SLV_DATA: begin
        if (M_AXIL_RVALID) state_nxt_s = RESP;
        else               state_nxt_s = SLV_DATA;
      end
      RESP: begin
        if (rready_sel_s) state_nxt_s = IDLE;
        else              state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant bookkeeping and registered channel payloads
  always_ff @(posedge S_AXIL_ACLK) begin
    if (S_AXIL_ARESET) begin
      grant_r      <= '0;
      last_grant_r <= IDX_W'(NUM_MASTERS - 1);
      m_arvalid_r  <= 1'b0;
      m_araddr_r   <= '0;
      m_arprot_r   <= 3'b000;
      s_rdata_r    <= '0;
      s_rresp_r    <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) grant_r <= pick_idx_s;
        end
        ADDR_ACCEPT: begin
          if (in_range_s) begin
            m_araddr_r  <= sel_addr_s;
            m_arprot_r  <= sel_prot_s;
            m_arvalid_r <= 1'b1;
          end else begin
            s_rdata_r <= '0;
            s_rresp_r <= 2'b11;
          end
        end
        SLV_ADDR: begin
          if (M_AXIL_ARREADY) m_arvalid_r <= 1'b0;
        end
        SLV_DATA: begin
          if (M_AXIL_RVALID) begin
            s_rdata_r <= M_AXIL_RDATA;
            s_rresp_r <= M_AXIL_RRESP;
          end
        end
        RESP: begin
          if (rready_sel_s) last_grant_r <= grant_r;
        end
        default: begin
          m_arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // One-hot handshake strobes decoded from the registered state and grant
  always_comb begin
    arready_s = '0;
    rvalid_s  = '0;
    if (state_r == ADDR_ACCEPT) begin
      arready_s[grant_r] = 1'b1;
    end else begin
      arready_s = '0;
    end
    if (state_r == RESP) begin
      rvalid_s[grant_r] = 1'b1;
    end else begin
      rvalid_s = '0;
    end
  end

  assign S_AXIL_ARREADY = arready_s;
  assign S_AXIL_RVALID  = rvalid_s;
  assign S_AXIL_RDATA   = s_rdata_r;
  assign S_AXIL_RRESP   = s_rresp_r;
  assign M_AXIL_ARVALID = m_arvalid_r;
  assign M_AXIL_ARADDR  = m_araddr_r;
  assign M_AXIL_ARPROT  = m_arprot_r;
  assign M_AXIL_RREADY  = (state_r == SLV_DATA);
  assign grant_idx      = grant_r;
  assign busy           = (state_r != IDLE);

endmodule
